// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC actuator sequencer.
// State encodings are fixed so the debug port matches the board docs.
package hvac_pkg;

   typedef logic [1:0] hvac_state_t;

   localparam hvac_state_t ST_IDLE = 2'b00;
   localparam hvac_state_t ST_HEAT = 2'b01;
   localparam hvac_state_t ST_COOL = 2'b10;
   localparam hvac_state_t ST_HOLD = 2'b11;

   localparam int MIN_ON_DEF  = 4;
   localparam int MIN_OFF_DEF = 3;

   function automatic int hvac_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter shared by the run and rest phases.
// done_o flags that the count has reached the current terminal value.
module dwell_counter #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          en_i,
   input  logic [CW-1:0] term_i,
   output logic          done_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != term_i)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/hvac_sequencer.sv
// Heat/cool actuator sequencer with minimum run and rest dwell times.
// Every run passes through HOLD then IDLE, so no direct changeover.
module hvac_sequencer
   import hvac_pkg::*;
#(
   parameter int MIN_ON  = MIN_ON_DEF,
   parameter int MIN_OFF = MIN_OFF_DEF,
   parameter int CW      = $clog2(hvac_max(MIN_ON, MIN_OFF) + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       heat_req,
   input  logic       cool_req,
   output logic       heater_en,
   output logic       cooler_en,
   output logic       busy,
   output logic       conflict,
   output logic [1:0] state
);

   hvac_state_t   state_q;
   hvac_state_t   state_d;
   logic          conflict_q;
   logic          conflict_d;
   logic          dwell_done;
   logic          dwell_clr;
   logic          dwell_en;
   logic [CW-1:0] dwell_term;
   logic          heat_rel;
   logic          cool_rel;

   assign heat_rel = !heat_req || !enable;
   assign cool_rel = !cool_req || !enable;

   always_comb begin
      state_d    = state_q;
      conflict_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && heat_req && cool_req) begin
               conflict_d = 1'b1;
            end else if (enable && heat_req) begin
               state_d = ST_HEAT;
            end else if (enable && cool_req) begin
               state_d = ST_COOL;
            end
         end
         ST_HEAT: begin
            if (dwell_done && heat_rel) begin
               state_d = ST_HOLD;
            end
         end
         ST_COOL: begin
            if (dwell_done && cool_rel) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (dwell_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter restarts from zero on every phase change and idles cleared.
   assign dwell_clr  = (state_q == ST_IDLE) || (state_d != state_q);
   assign dwell_en   = (state_q != ST_IDLE);
   assign dwell_term = (state_q == ST_HOLD) ? CW'(MIN_OFF - 1)
                                            : CW'(MIN_ON - 1);

   dwell_counter #(
      .CW (CW)
   ) u_dwell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (dwell_clr),
      .en_i    (dwell_en),
      .term_i  (dwell_term),
      .done_o  (dwell_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         conflict_q <= conflict_d;
      end
   end

   assign heater_en = (state_q == ST_HEAT);
   assign cooler_en = (state_q == ST_COOL);
   assign busy      = (state_q != ST_IDLE);
   assign conflict  = conflict_q;
   assign state     = state_q;

endmodule
